// File: rtl/full_wptr_if.sv
// Write-side bundle of the async FIFO: client request, synchronized-in read pointer, memory write port and flags.
// wafull exists only when FIFO_ALMOST_FULL_EN is defined.
interface full_wptr_if #(
  parameter int WIDTH = 3
);
  logic             winc;
  logic [WIDTH:0]   grptr;
  logic             wen;
  logic [WIDTH-1:0] waddr;
  logic [WIDTH:0]   gwptr;
  logic [WIDTH:0]   gwptr_next;
  logic             wfull;
`ifdef FIFO_ALMOST_FULL_EN
  logic             wafull;

  modport master (
    output winc, grptr,
    input  wen, waddr, gwptr, gwptr_next, wfull, wafull
  );
  modport slave (
    input  winc, grptr,
    output wen, waddr, gwptr, gwptr_next, wfull, wafull
  );
`else
  modport master (
    output winc, grptr,
    input  wen, waddr, gwptr, gwptr_next, wfull
  );
  modport slave (
    input  winc, grptr,
    output wen, waddr, gwptr, gwptr_next, wfull
  );
`endif
endinterface

// File: rtl/full_wptr.sv
// Async FIFO write-side pointer and pessimistic registered full flag; the WIDTH parameter must match the bus interface.
// Optional registered almost-full flag under FIFO_ALMOST_FULL_EN.
module full_wptr #(
  parameter int WIDTH = 3
) (
  input  logic       wclk,
  input  logic       wrst,
  full_wptr_if.slave bus
);

  function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    for (int i = 0; i <= WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [WIDTH:0] wbin;
  logic [WIDTH:0] wbin_next;
  logic [WIDTH:0] gwptr_q;
  logic [WIDTH:0] rq1;
  logic [WIDTH:0] rq2;
  logic [WIDTH:0] rbin_s;
  logic           wfull_q;
  logic           wen;
  logic           full_term;

  assign wen       = bus.winc & ~wfull_q;
  assign wbin_next = wbin + (WIDTH+1)'(wen);
  assign rbin_s    = gray2bin(rq2);
  // rbin_s lags the true read pointer, so this can only over-report fullness.
  assign full_term = (wbin_next[WIDTH] != rbin_s[WIDTH]) &&
                     (wbin_next[WIDTH-1:0] == rbin_s[WIDTH-1:0]);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin    <= '0;
      gwptr_q <= '0;
      rq1     <= '0;
      rq2     <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      gwptr_q <= bin2gray(wbin_next);
      rq1     <= bus.grptr;
      rq2     <= rq1;
      wfull_q <= full_term;
    end
  end

  assign bus.wen        = wen;
  assign bus.waddr      = wbin[WIDTH-1:0];
  assign bus.gwptr      = gwptr_q;
  assign bus.gwptr_next = bin2gray(wbin_next);
  assign bus.wfull      = wfull_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [WIDTH:0] AFULL_LVL = (WIDTH+1)'((1 << WIDTH) - 1);

  logic [WIDTH:0] fill_lvl;
  logic           wafull_q;

  assign fill_lvl = wbin_next - rbin_s;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull_q <= 1'b0;
    end else begin
      wafull_q <= (fill_lvl >= AFULL_LVL);
    end
  end

  assign bus.wafull = wafull_q;
`endif

endmodule

// File: doc/full_wptr.md
# full_wptr

Write-side pointer and full-flag block of the asynchronous FIFO, the write-domain counterpart of the read-side empty logic. It owns the binary and Gray write pointers, synchronizes the read domain's Gray read pointer into the write clock, converts it to binary and drives a registered, pessimistic `wfull`. It sits between the write client, the dual-port memory write port and the read-side pointer/empty logic, which consumes `gwptr_next`.

## Interface
- `WIDTH`, 3: address width; depth = 2**WIDTH; pointers are WIDTH+1 bits. Legal range WIDTH >= 1.
- `wclk`  input  1  write clock; every register in the block is on its rising edge.
- `wrst`  input  1  reset, synchronous, active-high.
- `winc`  input  1  write request from the client.
- `grptr`  input  WIDTH+1  Gray read pointer from the read domain; asynchronous to `wclk`.
- `wen`  output  1  memory write enable, combinational: `winc & ~wfull`.
- `waddr`  output  WIDTH  memory write address, equal to `wbin[WIDTH-1:0]`.
- `gwptr`  output  WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- `gwptr_next`  output  WIDTH+1  combinational next Gray write pointer.
- `wfull`  output  1  registered full flag.
- `wafull`  output  1  registered almost-full flag; present only under `FIFO_ALMOST_FULL_EN`.

## Operation
- Internal `wbin` is the binary write pointer, WIDTH+1 bits.
- `wbin_next = wbin + wen`; the add is modulo 2**(WIDTH+1) and wraps silently.
- `gwptr_next = wbin_next ^ (wbin_next >> 1)`.
- On each edge: `wbin <= wbin_next` and `gwptr <= gwptr_next`.
- Read-pointer synchronizer: two flops, `grptr -> rq1 -> rq2`, with no logic between stages.
- `rbin_s[i] = ^(rq2 >> i)` for i = 0..WIDTH, converting the synchronized Gray pointer to binary.
- Full term: `(wbin_next[WIDTH] != rbin_s[WIDTH]) && (wbin_next[WIDTH-1:0] == rbin_s[WIDTH-1:0])`.
  - `wfull` registers this term every cycle.
- Writes while full: `wen = 0`; `wbin`, `gwptr` and `waddr` hold; the write is dropped with no error flag.
- `wfull` is pessimistic, because `rbin_s` lags the real read pointer.
  - It never under-reports occupancy.
  - It may stay high for a few cycles after the reader frees space.

## Timing
- Reset (`wrst` = 1 at an edge):
  - `wbin`, `gwptr`, `rq1`, `rq2` = 0; `wfull` = 0; `wafull` = 0.
  - `waddr` = 0 and `gwptr_next` = 0 while `winc` = 0.
- Reset overrides `winc`, including mid-fill or while full.
- The read domain must be reset in the same window; this block does not enforce it.
- A write is accepted in any cycle with `winc` = 1 and `wfull` = 0; memory captures data at `waddr` on that edge.
- `gwptr` and `waddr` advance on the same edge as the accepted write.
- `wfull` rises on the same edge as the write that fills the FIFO, so the next cycle's `winc` is already blocked.
- When `grptr` changes, `wfull` can fall on the 3rd rising edge after the change: rq1, then rq2, then the flag register.
- Simultaneous filling write and a `grptr` advance: the stale `rq2` is used, so `wfull` asserts and clears 3 edges later.
- `gwptr` changes at most one bit per edge, which makes it safe for the read-side synchronizer.

## Configuration
- Macro `FIFO_ALMOST_FULL_EN`.
- Defined:
  - The `wafull` port exists.
  - `wafull` is registered with the term `(wbin_next - rbin_s) >= 2**WIDTH - 1`, computed modulo 2**(WIDTH+1).
  - Reset value 0; same latency as `wfull`.
- Undefined:
  - No port and no logic.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 3 (depth 8).
- Reset with `winc` = 1 and `grptr` = 4'b0000 -> after reset: `wfull` = 0, `gwptr` = 0000, `waddr` = 0, `wen` = 1.
- Fill: `grptr` = 0000, 8 consecutive `winc` -> `waddr` walks 0..7; after the 8th edge `wfull` = 1 and `gwptr` = 4'b1100 (binary 8).
  - A 9th `winc` leaves `wen` = 0 and `gwptr` = 1100.
- Drain release: from full, set `grptr` = 4'b0001 -> `wfull` = 1 for 2 more edges, 0 after the 3rd edge.
  - The next `winc` writes `waddr` = 0 and `gwptr` becomes 4'b1101.
- Wrap: 16 writes with `grptr` tracking each write 3 cycles late -> `wfull` never set; `wbin` wraps 15 -> 0 and `gwptr` returns to 0000.
- Reset mid-fill: after 5 writes (`gwptr` = 0111), assert `wrst` with `winc` = 1 -> next edge `gwptr` = 0000, `waddr` = 0, `wfull` = 0.
- With `FIFO_ALMOST_FULL_EN` and `grptr` = 0000:
  - After the 7th write `wafull` = 1 and `wfull` = 0.
  - After the 8th write both are 1.
